skewed_row_feeder: RTL and testbench

SKEWED_ROW_FEEDER -- requirements
Module: skewed_row_feeder

---
 rtl/skewed_row_feeder.sv | 118 +++++++++++
 tb/tb_skewed_row_feeder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/skewed_row_feeder.sv
// Streams a captured ROWS x COLS matrix out one column per cycle, one lane per row.
// With skew enabled, row r is delayed r cycles to form the diagonal wavefront a systolic array expects.
module skewed_row_feeder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ROWS  = 2,
  parameter int unsigned COLS  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ROWS*COLS*WIDTH-1:0]  mat_in,
  input  logic                        in_valid,
  input  logic                        skew_en,
  output logic                        in_ready,
  output logic [ROWS*WIDTH-1:0]       data_out,
  output logic [ROWS-1:0]             valid_out,
  output logic                        done
);

  localparam int unsigned LMax = COLS + ROWS - 1;
  localparam int unsigned CntW = $clog2(LMax) + 1;
  localparam logic [CntW-1:0] LastSkew  = CntW'(LMax - 1);
  localparam logic [CntW-1:0] LastAlign = CntW'(COLS - 1);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                      r_state, w_state_d;
  logic [CntW-1:0]             r_cnt, w_cnt_d;
  logic                        r_skew;
  logic [ROWS*COLS*WIDTH-1:0]  r_buf;

  logic [CntW-1:0]             w_last, w_k;
  logic                        w_is_last, w_accept, w_emit, w_src_skew;
  logic [ROWS*COLS*WIDTH-1:0]  w_src_mat;
  logic [ROWS*WIDTH-1:0]       w_data_d;
  logic [ROWS-1:0]             w_valid_d;
  logic                        w_done_d;

  assign w_last    = r_skew ? LastSkew : LastAlign;
  assign w_is_last = (r_state == StStream) && (r_cnt == w_last);
  assign in_ready  = !rst && ((r_state == StIdle) || w_is_last);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StStream;
          w_cnt_d   = '0;
        end
      end
      StStream: begin
        if (w_accept) begin
          w_cnt_d = '0;
        end else if (w_is_last) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output registers are loaded with the element for the stream step about to be shown;
  // on accept that is step 0 taken straight from mat_in, giving latency 1 with no gap.
  assign w_src_mat  = w_accept ? mat_in : r_buf;
  assign w_src_skew = w_accept ? skew_en : r_skew;
  assign w_k        = w_accept ? '0 : r_cnt + CntW'(1);
  assign w_emit     = w_accept || ((r_state == StStream) && !w_is_last);
  assign w_done_d   = w_emit && (w_k == (w_src_skew ? LastSkew : LastAlign));

  always_comb begin
    int k_i;
    int sk_i;
    w_data_d  = '0;
    w_valid_d = '0;
    k_i       = int'(w_k);
    sk_i      = w_src_skew ? 1 : 0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        if (w_emit && (k_i == c + r * sk_i)) begin
          w_data_d[r*WIDTH +: WIDTH] = w_src_mat[(r*COLS+c)*WIDTH +: WIDTH];
          w_valid_d[r]               = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_skew    <= 1'b0;
      data_out  <= '0;
      valid_out <= '0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      data_out  <= w_data_d;
      valid_out <= w_valid_d;
      done      <= w_done_d;
      if (w_accept) begin
        r_skew <= skew_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf <= mat_in;
    end
  end

endmodule

// File: tb/tb_skewed_row_feeder.sv
// Scoreboard bench: a 2x2 and a 4x3 instance; each accepted block pushes its per-cycle
// expected lane contents, which are popped and compared on every falling edge.
module tb_skewed_row_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, in_valid_a, skew_a, in_ready_a, done_a;
  logic [63:0]  mat_a;
  logic [31:0]  data_out_a;
  logic [1:0]   valid_out_a;

  logic         rst_b, in_valid_b, skew_b, in_ready_b, done_b;
  logic [191:0] mat_b;
  logic [63:0]  data_out_b;
  logic [3:0]   valid_out_b;

  skewed_row_feeder #(.WIDTH(16), .ROWS(2), .COLS(2)) u_dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .mat_in    (mat_a),
    .in_valid  (in_valid_a),
    .skew_en   (skew_a),
    .in_ready  (in_ready_a),
    .data_out  (data_out_a),
    .valid_out (valid_out_a),
    .done      (done_a)
  );

  skewed_row_feeder #(.WIDTH(16), .ROWS(4), .COLS(3)) u_dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .mat_in    (mat_b),
    .in_valid  (in_valid_b),
    .skew_en   (skew_b),
    .in_ready  (in_ready_b),
    .data_out  (data_out_b),
    .valid_out (valid_out_b),
    .done      (done_b)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  valid;
    logic        done;
  } exp_t;

  exp_t q[$];
  bit   sel_b = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Element (r,c) is due on lane r at stream step c + r*skew; step L-1 carries done.
  function automatic void push_block(input logic [191:0] m, input bit sk);
    exp_t e;
    int rows, cols, s, l, c;
    rows = sel_b ? 4 : 2;
    cols = sel_b ? 3 : 2;
    s    = sk ? 1 : 0;
    l    = cols + (rows - 1) * s;
    for (int k = 0; k < l; k++) begin
      e.data  = '0;
      e.valid = '0;
      for (int r = 0; r < rows; r++) begin
        c = k - r * s;
        if (c >= 0 && c < cols) begin
          e.data[r*16 +: 16] = m[(r*cols+c)*16 +: 16];
          e.valid[r]         = 1'b1;
        end
      end
      e.done = (k == l - 1);
      q.push_back(e);
    end
  endfunction

  task automatic step(input bit rst_v, input bit vld_v, input bit sk_v,
                      input logic [191:0] mat_v);
    exp_t        e;
    logic [63:0] got_d;
    logic [3:0]  got_v;
    logic        got_done, got_rdy;
    bit          exp_rdy;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
    end else begin
      e.data  = '0;
      e.valid = '0;
      e.done  = 1'b0;
    end
    if (sel_b) begin
      got_d = data_out_b;  got_v = valid_out_b;         got_done = done_b;
    end else begin
      got_d = {32'h0, data_out_a}; got_v = {2'b00, valid_out_a}; got_done = done_a;
    end
    check_eq(sel_b ? "b_data" : "a_data", got_d, e.data);
    check_eq(sel_b ? "b_valid" : "a_valid", {60'h0, got_v}, {60'h0, e.valid});
    check_eq(sel_b ? "b_done" : "a_done", {63'h0, got_done}, {63'h0, e.done});
    if (sel_b) begin
      rst_b = rst_v; in_valid_b = vld_v; skew_b = sk_v; mat_b = mat_v;
    end else begin
      rst_a = rst_v; in_valid_a = vld_v; skew_a = sk_v; mat_a = mat_v[63:0];
    end
    #1;
    exp_rdy = !rst_v && (q.size() == 0);
    got_rdy = sel_b ? in_ready_b : in_ready_a;
    check_eq(sel_b ? "b_ready" : "a_ready", {63'h0, got_rdy}, {63'h0, exp_rdy});
    if (rst_v) q.delete();
    else if (vld_v && exp_rdy) push_block(mat_v, sk_v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [191:0] rand_mat();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [191:0] m1, m2, mb;

  initial begin
    rst_a = 1'b1; in_valid_a = 1'b0; skew_a = 1'b0; mat_a = '0;
    rst_b = 1'b1; in_valid_b = 1'b0; skew_b = 1'b0; mat_b = '0;
    m1 = {128'h0, 16'h0300, 16'h0200, 16'h0100, 16'h0400};
    m2 = {128'h0, 16'hfff3, 16'h8002, 16'h7f01, 16'h1234};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // 2x2: skewed, aligned, back-to-back with in_valid held, reset mid-stream
    step(1'b0, 1'b1, 1'b1, m1);  idle(5);
    step(1'b0, 1'b1, 1'b0, m1);  idle(4);
    step(1'b0, 1'b1, 1'b1, m1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, (i == 2) ? m2 : rand_mat());
    idle(5);
    step(1'b0, 1'b1, 1'b1, m1);
    step(1'b0, 1'b1, 1'b0, m2);
    step(1'b1, 1'b1, 1'b1, m2);
    step(1'b0, 1'b0, 1'b0, '0);
    idle(4);
    for (int i = 0; i < 30; i++)
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
           rand_mat());
    idle(6);

    // 4x3 instance
    sel_b = 1'b1;
    mb = rand_mat();
    step(1'b0, 1'b1, 1'b1, mb);  idle(8);
    step(1'b0, 1'b1, 1'b0, mb);  idle(5);
    step(1'b0, 1'b1, 1'b1, mb);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, (i % 2) == 0, rand_mat());
    idle(8);
    step(1'b0, 1'b1, 1'b1, mb);
    idle(2);
    step(1'b1, 1'b0, 1'b0, '0);
    idle(4);
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
           rand_mat());
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
